hazard_sched_ctrl: RTL and testbench
====================================

Name: hazard_sched_ctrl

Overview:
- Central hazard and stall scheduler for the RV64 5-stage pipeline (IF/ID/EX/MEM/WB).
- Takes the decoded operand fields of the instruction in ID and the destination info of EX, MEM and WB. From these it produces:
  - operand forwarding selects;
  - the load-use stall and bubble;
  - redirect flushes;
  - EX hold for multi-cycle mul/div operations, sequenced by an internal FSM.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LAT, 3, total EX cycles for ALU_ctrl codes 19..22 (mul family); must be >=2
DIV_LAT, 34, total EX cycles for ALU_ctrl codes 23..30 (div/rem family); must be >=2
CNT_W, 6, latency counter width; must satisfy 2^CNT_W > max(MUL_LAT,DIV_LAT)

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-low reset (sampled on posedge clk, asserted when 0)
id_valid  in  1  ID holds a valid instruction
id_rs  in  5  source register 1 of ID instruction
id_rt  in  5  source register 2 of ID instruction
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
ex_valid  in  1  EX holds a valid instruction
ex_rd  in  5  EX destination register
ex_reg_w_en  in  1  EX writes a register
ex_is_load  in  1  EX instruction is a load (WB_sel=1)
ex_alu_ctrl  in  5  EX ALU control code (0..30; 31 = invalid)
ex_redirect  in  1  EX resolved taken branch/jalr (PC redirect)
mem_valid / mem_rd / mem_reg_w_en  in  1/5/1  MEM stage destination info
wb_valid / wb_rd / wb_reg_w_en  in  1/5/1  WB stage destination info
fwd1_sel  out  2  rs source: 0 regfile, 1 MEM result, 2 WB data
fwd2_sel  out  2  rt source, same encoding
id_stall  out  1  hold IF/ID registers (drives ID ready low)
ex_bubble  out  1  load NOP into ID/EX register this cycle
ex_hold  out  1  hold ID/EX register and ALU operands
flush_id  out  1  invalidate IF/ID contents
md_busy  out  1  mul/div FSM not IDLE
md_done  out  1  one-cycle pulse: mul/div result valid this cycle
stall_cnt  out  32  saturating count of cycles with id_stall=1

Behaviour:
- Reset (reset==0 at posedge):
  - FSM goes to IDLE, counter clears to 0, stall_cnt clears to 0.
  - Outputs while in reset: all select/control outputs are 0, except those driven combinationally from inputs (fwd selects, load-use stall). This is deliberate: a reset mid mul/div abandons the operation and no md_done is produced.
- Forwarding (combinational, zero latency), evaluated independently for rs and rt:
  - MEM match: mem_valid & mem_reg_w_en & mem_rd!=0 & mem_rd==src -> sel=1.
  - Otherwise WB match: wb_valid & wb_reg_w_en & wb_rd!=0 & wb_rd==src -> sel=2.
  - Otherwise sel=0. MEM has priority over WB. x0 is never forwarded.
- Load-use:
  - lu = id_valid & ex_valid & ex_is_load & ex_reg_w_en & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
  - lu gives exactly one stall cycle: id_stall=1, ex_bubble=1. The next cycle the load has moved to MEM and fwd sel=1 resolves the hazard.
- Mul/div FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when ex_valid and ex_alu_ctrl in 19..30. Counter loads MUL_LAT-2 (codes 19..22) or DIV_LAT-2 (codes 23..30).
  - BUSY: counter decrements each cycle. When counter==0, next state is DONE.
  - DONE: md_done=1, ex_hold=0; next state is IDLE.
  - Result: total EX occupancy is MUL_LAT or DIV_LAT cycles, counting the issue cycle.
  - ex_hold=1 in the IDLE issue cycle and in BUSY. ex_hold=0 in DONE.
  - md_busy=1 in BUSY and DONE.
  - In DONE, a new md op already in EX cannot start: the FSM must pass through IDLE first.
- Stall combination:
  - id_stall = ex_hold | lu, but forced to 0 when flush_id=1.
  - ex_bubble = lu & ~ex_hold (EX is held, not bubbled, while mul/div runs).
- Redirect:
  - flush_id = ex_redirect & ex_valid & ~ex_hold.
  - flush_id overrides lu: no stall and no bubble.
  - A redirect asserted while ex_hold=1 is ignored. It cannot legally occur, because branch codes are outside 19..30.
- stall_cnt increments by 1 in each cycle where id_stall=1, and saturates at 0xFFFF_FFFF (no wrap).
- ex_alu_ctrl=31 or any other non-md code never starts the FSM.

Test Plan:
- reset=0 for 2 cycles while ex_alu_ctrl=23 & ex_valid=1 -> FSM IDLE, md_busy=0, stall_cnt=0. On the release cycle, ex_hold=1 and the FSM enters BUSY.
- mem_rd=5 & mem_reg_w_en, wb_rd=5 & wb_reg_w_en, id_rs=5 & id_use_rs -> fwd1_sel=1. Repeat with mem_rd=0, id_rs=0 and all writers targeting x0 -> fwd1_sel=0.
- EX ld x7; ID add x9,x7,x3 -> exactly one cycle id_stall=1, ex_bubble=1. Next cycle (load in MEM) id_stall=0, fwd1_sel=1, stall_cnt=1.
- mul issue (code 19), MUL_LAT=3 -> ex_hold=1 for 2 cycles, md_done pulse in cycle 3, stall_cnt+=2. Div (code 23), DIV_LAT=34 -> ex_hold=1 for 33 cycles, md_done in cycle 34.
- lu and ex_redirect=1 in the same cycle -> flush_id=1, id_stall=0, ex_bubble=0. Redirect during div BUSY -> flush_id=0.
- Force stall_cnt to 0xFFFF_FFFE, hold id_stall=1 for 3 cycles -> stall_cnt stays at 0xFFFF_FFFF. reset=0 during div BUSY -> IDLE next cycle, no md_done ever pulses.

Source files
------------

// File: rtl/hazard_sched_ctrl_if.sv
// rtl/hazard_sched_ctrl_if.sv - pipeline stage info in, forwarding/stall controls out
interface hazard_sched_ctrl_if;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_use_rs;
   logic        id_use_rt;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic        ex_reg_w_en;
   logic        ex_is_load;
   logic [4:0]  ex_alu_ctrl;
   logic        ex_redirect;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic        mem_reg_w_en;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_reg_w_en;
   logic [1:0]  fwd1_sel;
   logic [1:0]  fwd2_sel;
   logic        id_stall;
   logic        ex_bubble;
   logic        ex_hold;
   logic        flush_id;
   logic        md_busy;
   logic        md_done;
   logic [31:0] stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
      output ex_valid, ex_rd, ex_reg_w_en, ex_is_load, ex_alu_ctrl, ex_redirect,
      output mem_valid, mem_rd, mem_reg_w_en, wb_valid, wb_rd, wb_reg_w_en,
      input  fwd1_sel, fwd2_sel, id_stall, ex_bubble, ex_hold, flush_id,
      input  md_busy, md_done, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
      input  ex_valid, ex_rd, ex_reg_w_en, ex_is_load, ex_alu_ctrl, ex_redirect,
      input  mem_valid, mem_rd, mem_reg_w_en, wb_valid, wb_rd, wb_reg_w_en,
      output fwd1_sel, fwd2_sel, id_stall, ex_bubble, ex_hold, flush_id,
      output md_busy, md_done, stall_cnt
   );
endinterface

// File: rtl/hazard_sched_ctrl.sv
// rtl/hazard_sched_ctrl.sv - RV64 5-stage hazard/stall scheduler with mul/div EX sequencer
module hazard_sched_ctrl #(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 34,
   parameter int CNT_W   = 6
) (
   input logic                 clk,
   input logic                 reset,
   hazard_sched_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

   md_state_t        state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [31:0]      stall_cnt_q;
   logic             is_mul, is_div, md_start;
   logic             hold_raw, busy_raw, done_raw;
   logic             ex_hold, lu, flush_id, id_stall;
   logic [CNT_W-1:0] load_val;

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic mem_v, input logic mem_w, input logic [4:0] mem_d,
      input logic wb_v,  input logic wb_w,  input logic [4:0] wb_d
   );
      if (mem_v && mem_w && mem_d != 5'd0 && mem_d == src)
         return 2'd1;
      else if (wb_v && wb_w && wb_d != 5'd0 && wb_d == src)
         return 2'd2;
      else
         return 2'd0;
   endfunction

   assign bus.fwd1_sel = fwd_sel(bus.id_rs, bus.mem_valid, bus.mem_reg_w_en, bus.mem_rd,
                                 bus.wb_valid, bus.wb_reg_w_en, bus.wb_rd);
   assign bus.fwd2_sel = fwd_sel(bus.id_rt, bus.mem_valid, bus.mem_reg_w_en, bus.mem_rd,
                                 bus.wb_valid, bus.wb_reg_w_en, bus.wb_rd);

   assign lu = bus.id_valid && bus.ex_valid && bus.ex_is_load && bus.ex_reg_w_en &&
               bus.ex_rd != 5'd0 &&
               ((bus.id_use_rs && bus.id_rs == bus.ex_rd) ||
                (bus.id_use_rt && bus.id_rt == bus.ex_rd));

   assign is_mul   = bus.ex_alu_ctrl >= 5'd19 && bus.ex_alu_ctrl <= 5'd22;
   assign is_div   = bus.ex_alu_ctrl >= 5'd23 && bus.ex_alu_ctrl <= 5'd30;
   assign md_start = bus.ex_valid && (is_mul || is_div);
   assign load_val = is_mul ? MUL_LOAD : DIV_LOAD;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
      end
   end

   // cnt_q holds the BUSY cycles still to run; a zero load skips BUSY so LAT=2 still fits
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      hold_raw = 1'b0;
      busy_raw = 1'b0;
      done_raw = 1'b0;
      case (state_q)
         IDLE: begin
            if (md_start) begin
               hold_raw = 1'b1;
               cnt_n    = load_val;
               state_n  = (load_val == '0) ? DONE : BUSY;
            end
         end
         BUSY: begin
            hold_raw = 1'b1;
            busy_raw = 1'b1;
            cnt_n    = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1))
               state_n = DONE;
         end
         DONE: begin
            busy_raw = 1'b1;
            done_raw = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Reset abandons any mul/div in flight, so its controls are masked while reset is low
   assign ex_hold  = reset && hold_raw;
   assign flush_id = bus.ex_redirect && bus.ex_valid && !ex_hold;
   assign id_stall = (ex_hold || lu) && !flush_id;

   always_ff @(posedge clk) begin
      if (!reset)
         stall_cnt_q <= '0;
      else if (id_stall && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign bus.ex_hold   = ex_hold;
   assign bus.flush_id  = flush_id;
   assign bus.id_stall  = id_stall;
   assign bus.ex_bubble = lu && !ex_hold && !flush_id;
   assign bus.md_busy   = reset && busy_raw;
   assign bus.md_done   = reset && done_raw;
   assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// tb/tb_hazard_sched_ctrl.sv - directed bench for hazard_sched_ctrl
module tb_hazard_sched_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;
   logic [31:0] exp_cnt;
   logic saw_done;

   hazard_sched_ctrl_if bus ();

   hazard_sched_ctrl #(.MUL_LAT(3), .DIV_LAT(34), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
      bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_reg_w_en = 0; bus.ex_is_load = 0;
      bus.ex_alu_ctrl = 0; bus.ex_redirect = 0;
      bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_reg_w_en = 0;
      bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_reg_w_en = 0;
   endtask

   task automatic set_load_use();
      bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_reg_w_en = 1; bus.ex_rd = 7; bus.ex_alu_ctrl = 0;
      bus.id_valid = 1; bus.id_rs = 7; bus.id_use_rs = 1; bus.id_rt = 3; bus.id_use_rt = 1;
   endtask

   initial begin
      // reset held for two cycles with a div sitting in EX
      clear_inputs();
      reset = 0;
      bus.ex_valid = 1; bus.ex_alu_ctrl = 23;
      cyc();
      chk("rst_md_busy", 32'(bus.md_busy), 0);
      chk("rst_ex_hold", 32'(bus.ex_hold), 0);
      chk("rst_stall_cnt", bus.stall_cnt, 0);
      cyc();
      chk("rst2_md_busy", 32'(bus.md_busy), 0);
      chk("rst2_md_done", 32'(bus.md_done), 0);
      reset = 1;
      #1;
      chk("div_issue_hold", 32'(bus.ex_hold), 1);
      chk("div_issue_busy", 32'(bus.md_busy), 0);
      chk("div_issue_stall", 32'(bus.id_stall), 1);
      for (int c = 2; c <= 33; c++) begin
         cyc();
         if (c == 10) begin
            bus.ex_redirect = 1;
            #1;
            chk("div_redirect_flush", 32'(bus.flush_id), 0);
            bus.ex_redirect = 0;
         end
         chk($sformatf("div_hold_c%0d", c), 32'(bus.ex_hold), 1);
         chk($sformatf("div_busy_c%0d", c), 32'(bus.md_busy), 1);
         chk($sformatf("div_done_c%0d", c), 32'(bus.md_done), 0);
      end
      cyc();
      bus.ex_valid = 0;
      #1;
      chk("div_done_pulse", 32'(bus.md_done), 1);
      chk("div_done_hold", 32'(bus.ex_hold), 0);
      chk("div_done_busy", 32'(bus.md_busy), 1);
      exp_cnt = 33;
      chk("div_stall_cnt", bus.stall_cnt, exp_cnt);
      cyc();
      chk("div_idle_busy", 32'(bus.md_busy), 0);
      chk("div_idle_done", 32'(bus.md_done), 0);

      // forwarding priority and x0
      clear_inputs();
      bus.mem_valid = 1; bus.mem_rd = 5; bus.mem_reg_w_en = 1;
      bus.wb_valid = 1;  bus.wb_rd = 5;  bus.wb_reg_w_en = 1;
      bus.id_rs = 5; bus.id_use_rs = 1; bus.id_rt = 0;
      #1;
      chk("fwd1_mem_prio", 32'(bus.fwd1_sel), 1);
      chk("fwd2_none", 32'(bus.fwd2_sel), 0);
      bus.mem_reg_w_en = 0;
      #1;
      chk("fwd1_wb", 32'(bus.fwd1_sel), 2);
      bus.mem_reg_w_en = 1; bus.mem_rd = 5; bus.wb_rd = 6; bus.id_rt = 6;
      #1;
      chk("fwd2_wb", 32'(bus.fwd2_sel), 2);
      bus.mem_rd = 0; bus.wb_rd = 0; bus.id_rs = 0; bus.id_rt = 0;
      #1;
      chk("fwd1_x0", 32'(bus.fwd1_sel), 0);
      chk("fwd2_x0", 32'(bus.fwd2_sel), 0);

      // load-use: ld x7 in EX, add x9,x7,x3 in ID
      clear_inputs();
      set_load_use();
      #1;
      chk("lu_stall", 32'(bus.id_stall), 1);
      chk("lu_bubble", 32'(bus.ex_bubble), 1);
      chk("lu_flush", 32'(bus.flush_id), 0);
      cyc();
      bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_reg_w_en = 0; bus.ex_rd = 0;
      bus.mem_valid = 1; bus.mem_rd = 7; bus.mem_reg_w_en = 1;
      #1;
      exp_cnt = 34;
      chk("lu_next_stall", 32'(bus.id_stall), 0);
      chk("lu_next_bubble", 32'(bus.ex_bubble), 0);
      chk("lu_next_fwd1", 32'(bus.fwd1_sel), 1);
      chk("lu_stall_cnt", bus.stall_cnt, exp_cnt);
      clear_inputs();
      set_load_use();
      bus.id_rs = 1; bus.id_rt = 7;
      #1;
      chk("lu_rt_stall", 32'(bus.id_stall), 1);
      bus.id_use_rt = 0;
      #1;
      chk("lu_rt_unused", 32'(bus.id_stall), 0);
      bus.id_use_rt = 1; bus.ex_rd = 0; bus.id_rt = 0;
      #1;
      chk("lu_x0", 32'(bus.id_stall), 0);

      // mul: two hold cycles, done in the third
      clear_inputs();
      bus.ex_valid = 1; bus.ex_alu_ctrl = 19;
      #1;
      chk("mul_c1_hold", 32'(bus.ex_hold), 1);
      chk("mul_c1_busy", 32'(bus.md_busy), 0);
      cyc();
      chk("mul_c2_hold", 32'(bus.ex_hold), 1);
      chk("mul_c2_busy", 32'(bus.md_busy), 1);
      chk("mul_c2_done", 32'(bus.md_done), 0);
      cyc();
      bus.ex_valid = 0;
      #1;
      exp_cnt = 36;
      chk("mul_c3_hold", 32'(bus.ex_hold), 0);
      chk("mul_c3_done", 32'(bus.md_done), 1);
      chk("mul_stall_cnt", bus.stall_cnt, exp_cnt);
      cyc();
      chk("mul_c4_busy", 32'(bus.md_busy), 0);
      chk("mul_c4_done", 32'(bus.md_done), 0);

      // non-md codes never start the sequencer
      bus.ex_valid = 1; bus.ex_alu_ctrl = 31;
      #1;
      chk("code31_hold", 32'(bus.ex_hold), 0);
      cyc();
      chk("code31_busy", 32'(bus.md_busy), 0);
      bus.ex_alu_ctrl = 18;
      #1;
      chk("code18_hold", 32'(bus.ex_hold), 0);
      cyc();
      chk("code18_busy", 32'(bus.md_busy), 0);

      // redirect beats load-use
      clear_inputs();
      set_load_use();
      bus.ex_redirect = 1;
      #1;
      chk("redir_flush", 32'(bus.flush_id), 1);
      chk("redir_stall", 32'(bus.id_stall), 0);
      chk("redir_bubble", 32'(bus.ex_bubble), 0);
      cyc();
      chk("redir_stall_cnt", bus.stall_cnt, exp_cnt);

      // saturation
      clear_inputs();
      set_load_use();
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      #1;
      chk("sat_preload", bus.stall_cnt, 32'hFFFF_FFFE);
      for (int c = 0; c < 3; c++) begin
         cyc();
         chk($sformatf("sat_c%0d", c), bus.stall_cnt, 32'hFFFF_FFFF);
      end

      // reset mid-div abandons the operation
      clear_inputs();
      bus.ex_valid = 1; bus.ex_alu_ctrl = 23;
      cyc();
      chk("rdiv_busy", 32'(bus.md_busy), 1);
      reset = 0;
      bus.ex_valid = 0;
      #1;
      chk("rdiv_hold_masked", 32'(bus.ex_hold), 0);
      chk("rdiv_busy_masked", 32'(bus.md_busy), 0);
      cyc();
      reset = 1;
      #1;
      chk("rdiv_idle_busy", 32'(bus.md_busy), 0);
      chk("rdiv_stall_cnt", bus.stall_cnt, 0);
      saw_done = 0;
      for (int c = 0; c < 40; c++) begin
         cyc();
         if (bus.md_done) saw_done = 1;
      end
      chk("rdiv_no_done", 32'(saw_done), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
